qar_mmio_timer: RTL and testbench

QAR_MMIO_TIMER -- requirements
Module: qar_mmio_timer

---
 rtl/qar_mmio_pkg.sv | 21 ++
 rtl/qar_mmio_handshake.sv | 69 ++++++
 rtl/qar_mmio_timer.sv | 109 ++++++++++
 tb/tb_qar_mmio_timer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/qar_mmio_pkg.sv
// Shared MMIO definitions: register offsets, CTRL/STATUS bit positions and
// the bus handshake state encoding, reusable by other MMIO peripherals.
package qar_mmio_pkg;

    localparam logic [3:0] REG_CTRL   = 4'h0;
    localparam logic [3:0] REG_LOAD   = 4'h4;
    localparam logic [3:0] REG_COUNT  = 4'h8;
    localparam logic [3:0] REG_STATUS = 4'hC;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_AUTO   = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;
    localparam int unsigned STAT_PEND   = 0;

    typedef enum logic [1:0] {
        HS_IDLE = 2'd0,
        HS_WAIT = 2'd1,
        HS_RESP = 2'd2
    } hs_state_t;

endpackage

// File: rtl/qar_mmio_handshake.sv
// IDLE/WAIT/RESP bus handshake: optional wait states, one-cycle mem_ready
// and a matching commit strobe; an early mem_valid drop aborts the transfer.
module qar_mmio_handshake
    import qar_mmio_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic select,
    input  logic mem_valid,
    output logic start,
    output logic mem_ready,
    output logic commit
);

    localparam logic [2:0] WAIT_INIT = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

    hs_state_t  state;
    logic [2:0] wait_cnt;

    assign start = (state == HS_IDLE) && select;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HS_IDLE;
            wait_cnt  <= '0;
            mem_ready <= 1'b0;
            commit    <= 1'b0;
        end else begin
            case (state)
                HS_IDLE: begin
                    if (select) begin
                        if (WAIT_STATES == 0) begin
                            state     <= HS_RESP;
                            mem_ready <= 1'b1;
                            commit    <= 1'b1;
                        end else begin
                            state    <= HS_WAIT;
                            wait_cnt <= WAIT_INIT;
                        end
                    end
                end
                HS_WAIT: begin
                    if (!mem_valid) begin
                        state <= HS_IDLE;
                    end else if (wait_cnt == 3'd0) begin
                        state     <= HS_RESP;
                        mem_ready <= 1'b1;
                        commit    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                HS_RESP: begin
                    state     <= HS_IDLE;
                    mem_ready <= 1'b0;
                    commit    <= 1'b0;
                end
                default: begin
                    state     <= HS_IDLE;
                    mem_ready <= 1'b0;
                    commit    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/qar_mmio_timer.sv
// Memory-mapped down-counting timer with one-shot/auto-reload modes and a
// level interrupt cleared by ack or W1C write.
module qar_mmio_timer
    import qar_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        irq_timer,
    input  logic        irq_timer_ack
);

    logic        select, start, commit;
    logic        we_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [2:0]  ctrl;
    logic [31:0] load, count;
    logic        pending;
    logic [31:0] rdata_mux;
    logic        unused_addr;

    assign select      = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign unused_addr = ^mem_addr[1:0];

    qar_mmio_handshake #(.WAIT_STATES(WAIT_STATES)) u_hs (
        .clk       (clk),
        .rst_n     (rst_n),
        .select    (select),
        .mem_valid (mem_valid),
        .start     (start),
        .mem_ready (mem_ready),
        .commit    (commit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            off_q   <= '0;
            wdata_q <= '0;
        end else if (start) begin
            we_q    <= mem_we;
            off_q   <= mem_addr[3:2];
            wdata_q <= mem_wdata;
        end
    end

    logic wr, wr_ctrl, wr_load, wr_count, wr_status, expire;

    assign wr        = commit && we_q;
    assign wr_ctrl   = wr && ({off_q, 2'b00} == REG_CTRL);
    assign wr_load   = wr && ({off_q, 2'b00} == REG_LOAD);
    assign wr_count  = wr && ({off_q, 2'b00} == REG_COUNT);
    assign wr_status = wr && ({off_q, 2'b00} == REG_STATUS);
    assign expire    = ctrl[CTRL_EN] && (count == 32'd0);

    // Bus writes take priority over the timer's own update; expiry beats clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl    <= '0;
            load    <= '0;
            count   <= '0;
            pending <= 1'b0;
        end else begin
            if (wr_ctrl)
                ctrl <= wdata_q[2:0];
            else if (expire && !ctrl[CTRL_AUTO])
                ctrl[CTRL_EN] <= 1'b0;

            if (wr_load)
                load <= wdata_q;

            if (wr_count)
                count <= wdata_q;
            else if (expire && ctrl[CTRL_AUTO])
                count <= load;
            else if (ctrl[CTRL_EN] && !expire)
                count <= count - 32'd1;

            if (expire)
                pending <= 1'b1;
            else if (irq_timer_ack || (wr_status && wdata_q[STAT_PEND]))
                pending <= 1'b0;
        end
    end

    always_comb begin
        rdata_mux = '0;
        case ({off_q, 2'b00})
            REG_CTRL:   rdata_mux[2:0]      = ctrl;
            REG_LOAD:   rdata_mux           = load;
            REG_COUNT:  rdata_mux           = count;
            REG_STATUS: rdata_mux[STAT_PEND] = pending;
            default:    rdata_mux           = '0;
        endcase
    end

    assign mem_rdata = mem_ready ? rdata_mux : '0;
    assign irq_timer = pending && ctrl[CTRL_IRQ_EN];

endmodule

// File: tb/tb_qar_mmio_timer.sv
// Directed bench for qar_mmio_timer (WAIT_STATES=1): bus timing, timer
// expiry periods, interrupt ack/W1C behaviour, aborts and reset mid-transfer.
module tb_qar_mmio_timer;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        irq_timer_ack = 1'b0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        irq_timer;

    int tests = 0;
    int fails = 0;

    qar_mmio_timer #(.BASE_ADDR(BASE), .WAIT_STATES(1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_valid     (mem_valid),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .irq_timer     (irq_timer),
        .irq_timer_ack (irq_timer_ack)
    );

    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Returns at the negedge inside the RESP cycle; the commit edge follows.
    task automatic bus(input logic we, input logic [3:0] off, input logic [31:0] wd,
                       output logic [31:0] rd, output int lat);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_we    = we;
        mem_addr  = BASE + {28'd0, off};
        mem_wdata = wd;
        rd  = '0;
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (mem_ready) begin
                rd = mem_rdata;
                break;
            end
            if (lat >= 20) begin
                check32("bus_timeout_ready", {31'd0, mem_ready}, 32'd1);
                break;
            end
        end
        mem_valid = 1'b0;
        mem_we    = 1'b0;
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] wd);
        logic [31:0] rd;
        int lat;
        bus(1'b1, off, wd, rd, lat);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] off, input logic [31:0] exp);
        logic [31:0] rd;
        int lat;
        bus(1'b0, off, 32'd0, rd, lat);
        check32(tag, rd, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int lat, seen, k, j;

        // Reset state
        repeat (3) @(negedge clk);
        check32("rst_ready", {31'd0, mem_ready}, 32'd0);
        check32("rst_rdata", mem_rdata, 32'd0);
        check32("rst_irq", {31'd0, irq_timer}, 32'd0);
        rst_n = 1'b1;

        // Read CTRL after reset: latency 2, data 0, one-cycle pulse
        bus(1'b0, 4'h0, 32'd0, rd, lat);
        check32("ctrl_rst_rdata", rd, 32'd0);
        check32("read_latency", lat, 32'd2);
        @(negedge clk);
        check32("ready_pulse_width", {31'd0, mem_ready}, 32'd0);
        check32("rdata_idle_zero", mem_rdata, 32'd0);
        rd_chk("load_rst", 4'h4, 32'd0);
        rd_chk("count_rst", 4'h8, 32'd0);
        rd_chk("status_rst", 4'hC, 32'd0);

        // Unselected address BASE+0x10
        @(negedge clk);
        mem_valid = 1'b1;
        mem_we    = 1'b0;
        mem_addr  = BASE + 32'h10;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_ready) seen++;
        end
        mem_valid = 1'b0;
        check32("unsel_no_ready", seen, 32'd0);

        // Abort: drop mem_valid during WAIT of a LOAD write
        @(negedge clk);
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = BASE + 32'h4;
        mem_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (mem_ready) seen++;
        end
        check32("abort_no_ready", seen, 32'd0);
        bus(1'b0, 4'h4, 32'd0, rd, lat);
        check32("abort_no_write", rd, 32'd0);
        check32("abort_idle_latency", lat, 32'd2);

        // Reset asserted during WAIT of a LOAD=0x1234 write
        @(negedge clk);
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = BASE + 32'h4;
        mem_wdata = 32'h0000_1234;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check32("rst_mid_ready", {31'd0, mem_ready}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (mem_ready) seen++;
        end
        check32("rst_mid_no_ready", seen, 32'd0);
        rd_chk("rst_mid_load", 4'h4, 32'd0);

        // Auto-reload with interrupt: LOAD=5, COUNT=5, CTRL=7
        wr(4'h4, 32'd5);
        wr(4'h8, 32'd5);
        wr(4'h0, 32'd7);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!irq_timer && k < 20);
        check32("auto_first_rise", k - 1, 32'd6);
        for (int unsigned p = 0; p < 2; p++) begin
            irq_timer_ack = 1'b1;
            j = 0;
            do begin
                @(negedge clk);
                irq_timer_ack = 1'b0;
                j++;
            end while (!irq_timer && j < 20);
            check32("auto_period", j, 32'd6);
        end
        wr(4'h0, 32'd0);
        wr(4'hC, 32'd1);
        rd_chk("w1c_status", 4'hC, 32'd0);

        // One-shot: COUNT=3, CTRL=5
        wr(4'h8, 32'd3);
        wr(4'h0, 32'd5);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!irq_timer && k < 20);
        check32("oneshot_rise", k - 1, 32'd4);
        rd_chk("oneshot_ctrl", 4'h0, 32'd4);
        rd_chk("oneshot_count", 4'h8, 32'd0);
        wr(4'hC, 32'd0);
        @(negedge clk);
        check32("w0_no_clear_irq", {31'd0, irq_timer}, 32'd1);
        irq_timer_ack = 1'b1;
        @(negedge clk);
        irq_timer_ack = 1'b0;
        check32("ack_clears_irq", {31'd0, irq_timer}, 32'd0);
        rd_chk("ack_status", 4'hC, 32'd0);

        // Ack coinciding with expiry
        wr(4'h8, 32'd3);
        wr(4'h0, 32'd5);
        repeat (4) @(negedge clk);
        check32("pre_expiry_irq", {31'd0, irq_timer}, 32'd0);
        irq_timer_ack = 1'b1;
        @(negedge clk);
        check32("expiry_beats_ack", {31'd0, irq_timer}, 32'd1);
        irq_timer_ack = 1'b0;
        @(negedge clk);
        check32("expiry_beats_ack_hold", {31'd0, irq_timer}, 32'd1);
        rd_chk("expiry_status", 4'hC, 32'd1);
        wr(4'hC, 32'd1);
        rd_chk("w1c_after_expiry", 4'hC, 32'd0);

        // LOAD=0 with auto-reload expires every cycle, even with ack held
        wr(4'h4, 32'd0);
        wr(4'h8, 32'd0);
        wr(4'h0, 32'd3);
        irq_timer_ack = 1'b1;
        repeat (3) @(negedge clk);
        rd_chk("load0_pending_held", 4'hC, 32'd1);
        rd_chk("load0_count", 4'h8, 32'd0);
        irq_timer_ack = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
